div_unit: RTL and testbench

- Multicycle signed 32-bit divider. It is the responder on the DIV_control / divStop handshake driven by the control unit's execute and divide-by-zero states.
- Takes operands from the A/B registers and returns quotient (LO) and remainder (HI) to the HI/LO mux.
- Returns a done pulse and a divide-by-zero flag so the control unit can move on or enter its exception sequence.

---
 rtl/div_unit_pkg.sv | 12 +
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle divider and the divide-related states of the control unit.
package div_unit_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: LO = quotient (toward zero), HI = remainder (dividend's sign).
// Responds to a DIV_control start with a one-cycle divStop, flagging divide-by-zero via divZero.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DIV_control,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             divStop,
   output logic             divZero,
   output logic             busy
);

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
      return en ? (~x + WIDTH'(1)) : x;
   endfunction

   div_state_e       state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_q_q, sign_q_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             stop_q, stop_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d;

   // One extra guard bit so the trial-subtract sign is exact for every shifted remainder.
   logic [WIDTH+1:0] shift_w;
   logic [WIDTH+1:0] diff_w;

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      sign_q_d = sign_q_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      stop_d   = 1'b0;
      zero_d   = 1'b0;
      busy_d   = busy_q;
      shift_w  = {rem_q, quo_q[WIDTH-1]};
      diff_w   = shift_w - {2'b00, dvsr_q};

      case (state_q)
         DIV_IDLE: begin
            if (DIV_control) begin
               if (B == '0) begin
                  stop_d = 1'b1;
                  zero_d = 1'b1;
               end else begin
                  quo_d    = neg_if(A, A[WIDTH-1]);
                  dvsr_d   = neg_if(B, B[WIDTH-1]);
                  sign_a_d = A[WIDTH-1];
                  sign_q_d = A[WIDTH-1] ^ B[WIDTH-1];
                  rem_d    = '0;
                  cnt_d    = '0;
                  busy_d   = 1'b1;
                  state_d  = DIV_CALC;
               end
            end
         end
         DIV_CALC: begin
            if (!diff_w[WIDTH+1]) begin
               rem_d = diff_w[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = shift_w[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DIV_FIX;
            end
         end
         DIV_FIX: begin
            lo_d    = neg_if(quo_q, sign_q_q);
            hi_d    = neg_if(rem_q[WIDTH-1:0], sign_a_q);
            stop_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DIV_IDLE;
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= DIV_IDLE;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         sign_q_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         stop_q   <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         sign_q_q <= sign_q_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         stop_q   <= stop_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
      end
   end

   assign HI      = hi_q;
   assign LO      = lo_q;
   assign divStop = stop_q;
   assign divZero = zero_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands against a
// plain-arithmetic signed division model.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        DIV_control;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        divStop;
   logic        divZero;
   logic        busy;

   int errs   = 0;
   int checks = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .DIV_control(DIV_control), .A(A), .B(B),
      .HI(HI), .LO(LO), .divStop(divStop), .divZero(divZero), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // MIPS DIV semantics; the single overflow case wraps.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a;
         r = '0;
      end else begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end
   endfunction

   // Wait for divStop after an accepted start; optionally inject a stray request on cycle inj.
   task automatic wait_stop(input int inj, output int n);
      n = 0;
      do begin
         if (n + 1 == inj) begin
            DIV_control = 1'b1;
            A = 32'd1;
            B = 32'd0;
         end
         tick();
         n++;
         DIV_control = 1'b0;
         A = $urandom;
         B = $urandom;
      end while (!divStop && n < 40);
   endtask

   task automatic check_result(input string tag);
      check_eq({tag, "_lo"}, LO, exp_lo);
      check_eq({tag, "_hi"}, HI, exp_hi);
      check_eq({tag, "_zero"}, 32'(divZero), 32'd0);
   endtask

   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int inj, input string tag);
      int n;
      ref_div(a, b, exp_lo, exp_hi);
      A = a;
      B = b;
      DIV_control = 1'b1;
      tick();
      DIV_control = 1'b0;
      A = $urandom;
      B = $urandom;
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      wait_stop(inj, n);
      check_eq({tag, "_latency"}, 32'(n + 1), 32'd34);
      check_result(tag);
      tick();
      check_eq({tag, "_stop_pulse"}, 32'(divStop), 32'd0);
   endtask

   task automatic do_div_zero(input logic [31:0] a, input string tag);
      A = a;
      B = '0;
      DIV_control = 1'b1;
      tick();
      DIV_control = 1'b0;
      check_eq({tag, "_stop"}, 32'(divStop), 32'd1);
      check_eq({tag, "_zero"}, 32'(divZero), 32'd1);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_hi"}, HI, exp_hi);
      check_eq({tag, "_lo"}, LO, exp_lo);
      tick();
      check_eq({tag, "_stop_clr"}, 32'({divStop, divZero, busy}), 32'd0);
   endtask

   initial begin
      int n;
      int stops;
      logic [31:0] ra;
      logic [31:0] rb;

      reset = 1'b0;
      DIV_control = 1'b0;
      A = '0;
      B = '0;
      #12;
      check_eq("rst_hi", HI, 32'd0);
      check_eq("rst_lo", LO, 32'd0);
      check_eq("rst_flags", 32'({divStop, divZero, busy}), 32'd0);
      reset = 1'b1;
      tick();

      do_div(32'd7, 32'd2, 0, "d7_2");
      do_div(32'hFFFF_FFF9, 32'd2, 0, "dm7_2");
      check_eq("dm7_2_lo_abs", LO, 32'hFFFF_FFFD);
      check_eq("dm7_2_hi_abs", HI, 32'hFFFF_FFFF);
      do_div(32'd7, 32'hFFFF_FFFE, 0, "d7_m2");

      do_div(32'd100, 32'd3, 0, "d100_3");
      do_div_zero(32'd5, "dz5");
      check_eq("dz5_hi_keep", HI, 32'd1);
      check_eq("dz5_lo_keep", LO, 32'd33);

      do_div(32'h8000_0000, 32'hFFFF_FFFF, 0, "ovf");
      check_eq("ovf_lo_abs", LO, 32'h8000_0000);
      do_div(32'h8000_0000, 32'd1, 0, "mn_1");
      do_div(32'h8000_0000, 32'h8000_0000, 0, "mn_mn");

      do_div(32'd100, 32'd7, 9, "ign");
      check_eq("ign_lo_abs", LO, 32'd14);
      check_eq("ign_hi_abs", HI, 32'd2);

      // Reset mid-division: async clear and the division is abandoned.
      A = 32'd1000;
      B = 32'd3;
      DIV_control = 1'b1;
      tick();
      DIV_control = 1'b0;
      repeat (13) tick();
      #2;
      reset = 1'b0;
      #1;
      check_eq("mid_rst_hi", HI, 32'd0);
      check_eq("mid_rst_lo", LO, 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      exp_hi = '0;
      exp_lo = '0;
      stops = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (divStop) stops++;
      end
      check_eq("mid_rst_nostop", 32'(stops), 32'd0);
      check_eq("mid_rst_hold_lo", LO, 32'd0);
      do_div(32'd9, 32'd3, 0, "d9_3");

      // DIV_control held high: completion and the next start back-to-back.
      ra = $urandom;
      rb = $urandom | 32'd1;
      ref_div(ra, rb, exp_lo, exp_hi);
      A = ra;
      B = rb;
      DIV_control = 1'b1;
      tick();
      A = $urandom;
      B = $urandom;
      DIV_control = 1'b1;
      n = 0;
      while (!divStop && n < 40) begin
         tick();
         n++;
         A = $urandom;
         B = $urandom;
      end
      check_eq("b2b1_latency", 32'(n + 1), 32'd34);
      check_result("b2b1");
      ra = $urandom;
      rb = 32'($urandom_range(1, 1000));
      ref_div(ra, rb, exp_lo, exp_hi);
      A = ra;
      B = rb;
      tick();
      DIV_control = 1'b0;
      check_eq("b2b2_busy", 32'(busy), 32'd1);
      check_eq("b2b2_stop_low", 32'(divStop), 32'd0);
      wait_stop(0, n);
      check_eq("b2b2_latency", 32'(n + 1), 32'd34);
      check_result("b2b2");
      tick();

      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100));
         if (rb == '0) do_div_zero(ra, $sformatf("rnd%0d_dz", i));
         else do_div(ra, rb, 0, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
